// File: rtl/i2c_slave_block_if.sv
// Bus-side bundle for i2c_slave_block: SCL/SDA line levels, open-drain enable and byte handshakes.
interface i2c_slave_block_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_full_i;
  logic [7:0] tx_data_i;
  logic       tx_req_o;
  logic       master_nack_o;
  logic       start_o;
  logic       stop_o;
  logic       busy_o;

  modport slave (
    input  scl_i, sda_i, rx_full_i, tx_data_i,
    output sda_oe_o, rx_data_o, rx_valid_o, tx_req_o, master_nack_o, start_o, stop_o, busy_o
  );

  modport master (
    output scl_i, sda_i, rx_full_i, tx_data_i,
    input  sda_oe_o, rx_data_o, rx_valid_o, tx_req_o, master_nack_o, start_o, stop_o, busy_o
  );
endinterface

// File: rtl/i2c_slave_block.sv
// I2C target engine: oversampled SCL/SDA, fixed 7-bit address, byte RX/TX with ACK handling.
// Optional 3-sample majority filter on both lines when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module i2c_slave_block #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic             i2c_core_clock_i,
  input  logic             reset_i,
  i2c_slave_block_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT} state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_cur, sda_cur, scl_prev, sda_prev;

  // Idle bus is high; reset to 1 so leaving reset never looks like an edge.
  always_ff @(posedge i2c_core_clock_i or posedge reset_i) begin
    if (reset_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_i};
      sda_sync <= {sda_sync[0], bus.sda_i};
      scl_prev <= scl_cur;
      sda_prev <= sda_cur;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  always_ff @(posedge i2c_core_clock_i or posedge reset_i) begin
    if (reset_i) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_cur  <= 1'b1;
      sda_cur  <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_cur  <= (scl_hist[1] & scl_hist[0]) | (scl_hist[1] & scl_sync[1]) | (scl_hist[0] & scl_sync[1]);
      sda_cur  <= (sda_hist[1] & sda_hist[0]) | (sda_hist[1] & sda_sync[1]) | (sda_hist[0] & sda_sync[1]);
    end
  end
`else
  assign scl_cur = scl_sync[1];
  assign sda_cur = sda_sync[1];
`endif

  logic scl_rise, scl_fall, start_cond, stop_cond;
  assign scl_rise   = scl_cur & ~scl_prev;
  assign scl_fall   = ~scl_cur & scl_prev;
  assign start_cond = ~sda_cur & sda_prev & scl_cur & scl_prev;
  assign stop_cond  = sda_cur & ~sda_prev & scl_cur & scl_prev;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] sh, sh_n, rx_data, rx_data_n;
  logic       rw, rw_n, ack, ack_n, oe, oe_n, busy, busy_n;
  logic       rx_valid, rx_valid_n, mnack, mnack_n, start_p, start_n, stop_p, stop_n;
  logic       tx_load;

  always_ff @(posedge i2c_core_clock_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      rx_data  <= '0;
      rw       <= 1'b0;
      ack      <= 1'b0;
      oe       <= 1'b0;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      mnack    <= 1'b0;
      start_p  <= 1'b0;
      stop_p   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      rx_data  <= rx_data_n;
      rw       <= rw_n;
      ack      <= ack_n;
      oe       <= oe_n;
      busy     <= busy_n;
      rx_valid <= rx_valid_n;
      mnack    <= mnack_n;
      start_p  <= start_n;
      stop_p   <= stop_n;
    end
  end

  // In the ACK states cnt[0] marks the second (9th-clock) fall: first fall drives, second exits.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sh_n       = sh;
    rx_data_n  = rx_data;
    rw_n       = rw;
    ack_n      = ack;
    oe_n       = oe;
    busy_n     = busy;
    rx_valid_n = 1'b0;
    mnack_n    = 1'b0;
    start_n    = 1'b0;
    stop_n     = 1'b0;
    tx_load    = 1'b0;
    if (start_cond) begin
      state_n = ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
      start_n = 1'b1;
    end else if (stop_cond) begin
      state_n = IDLE;
      cnt_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
      stop_n  = 1'b1;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          sh_n  = {sh[6:0], sda_cur};
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            rw_n = sda_cur;
            if (sh[6:0] == SLAVE_ADDR) begin
              state_n = ADDR_ACK;
              busy_n  = 1'b1;
            end else begin
              state_n = WAIT;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!cnt[0]) begin
            oe_n  = 1'b1;
            cnt_n = 3'd1;
          end else begin
            cnt_n = '0;
            if (rw) begin
              tx_load = 1'b1;
              sh_n    = bus.tx_data_i;
              oe_n    = ~bus.tx_data_i[7];
              state_n = TX_DATA;
            end else begin
              oe_n    = 1'b0;
              state_n = RX_DATA;
            end
          end
        end
        RX_DATA: if (scl_rise) begin
          sh_n  = {sh[6:0], sda_cur};
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            ack_n   = ~bus.rx_full_i;
            state_n = RX_ACK;
            if (!bus.rx_full_i) begin
              rx_data_n  = {sh[6:0], sda_cur};
              rx_valid_n = 1'b1;
            end
          end
        end
        RX_ACK: if (scl_fall) begin
          if (!cnt[0]) begin
            oe_n  = ack;
            cnt_n = 3'd1;
          end else begin
            cnt_n = '0;
            oe_n  = 1'b0;
            if (ack) begin
              state_n = RX_DATA;
            end else begin
              state_n = WAIT;
              busy_n  = 1'b0;
            end
          end
        end
        TX_DATA: if (scl_fall) begin
          if (cnt == 3'd7) begin
            oe_n    = 1'b0;
            cnt_n   = '0;
            state_n = TX_ACK;
          end else begin
            sh_n  = {sh[6:0], 1'b0};
            oe_n  = ~sh[6];
            cnt_n = cnt + 3'd1;
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_cur) begin
              mnack_n = 1'b1;
              busy_n  = 1'b0;
              state_n = WAIT;
            end
          end else if (scl_fall) begin
            tx_load = 1'b1;
            sh_n    = bus.tx_data_i;
            oe_n    = ~bus.tx_data_i[7];
            cnt_n   = '0;
            state_n = TX_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe_o      = oe;
  assign bus.rx_data_o     = rx_data;
  assign bus.rx_valid_o    = rx_valid;
  assign bus.tx_req_o      = tx_load;
  assign bus.master_nack_o = mnack;
  assign bus.start_o       = start_p;
  assign bus.stop_o        = stop_p;
  assign bus.busy_o        = busy;
endmodule

// File: tb/tb_i2c_slave_block.sv
// Bench for i2c_slave_block: bit-banged I2C master, directed scenarios and randomized transactions.
module tb_i2c_slave_block;
  localparam int unsigned Q = 10;

  logic clk = 1'b0;
  logic rst;
  logic m_scl, m_sda;
  int unsigned vectors = 0, miscompares = 0;

  i2c_slave_block_if bus();

  i2c_slave_block #(.SLAVE_ADDR(7'h50)) dut (
    .i2c_core_clock_i(clk),
    .reset_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & ~bus.sda_oe_o;

  int unsigned n_start = 0, n_stop = 0, n_txreq = 0, n_mnack = 0, n_rxv = 0, n_oe = 0;
  logic [7:0] rx_got[$];

  always @(negedge clk) begin
    if (bus.start_o) n_start++;
    if (bus.stop_o) n_stop++;
    if (bus.tx_req_o) n_txreq++;
    if (bus.master_nack_o) n_mnack++;
    if (bus.sda_oe_o) n_oe++;
    if (bus.rx_valid_o) begin
      n_rxv++;
      rx_got.push_back(bus.rx_data_o);
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic m_start();
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic m_stop();
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1; wq();
  endtask

  task automatic m_bit(input logic b, output logic seen);
    m_sda = b;    wq();
    m_scl = 1'b1; wq();
    seen  = bus.sda_i; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic m_write(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(b[i], s);
    m_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic m_read(input logic mack, input logic [7:0] next, output logic [7:0] b);
    logic s;
    bus.tx_data_i = next;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      b[i] = s;
    end
    m_bit(~mack, s);
  endtask

  task automatic test_reset();
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    bus.rx_full_i = 1'b0; bus.tx_data_i = 8'h00;
    repeat (5) @(negedge clk);
    vectors++;
    if ({bus.sda_oe_o, bus.rx_data_o, bus.rx_valid_o, bus.tx_req_o, bus.master_nack_o,
         bus.start_o, bus.stop_o, bus.busy_o} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got oe=%b rx=%h v=%b tq=%b mn=%b st=%b sp=%b busy=%b, want all 0",
               bus.sda_oe_o, bus.rx_data_o, bus.rx_valid_o, bus.tx_req_o, bus.master_nack_o,
               bus.start_o, bus.stop_o, bus.busy_o);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int unsigned b_rx = rx_got.size(), b_stop = n_stop, b_rxv = n_rxv;
    m_start();
    m_write(8'hA0, a0);
    vectors++;
    if (bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL write_busy: got %b want 1", bus.busy_o); end
    m_write(8'hA5, a1);
    m_write(8'h3C, a2);
    m_stop();
    repeat (10) @(negedge clk);
    vectors++;
    if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL write_acks: got %b want 111", {a0, a1, a2}); end
    vectors++;
    if (n_rxv - b_rxv !== 2) begin miscompares++; $display("FAIL write_rxv_count: got %0d want 2", n_rxv - b_rxv); end
    vectors++;
    if (rx_got.size() < b_rx + 2 || rx_got[b_rx] !== 8'hA5 || rx_got[b_rx+1] !== 8'h3C) begin
      miscompares++; $display("FAIL write_rx_data: got %0d new bytes, want A5 3C", rx_got.size() - b_rx);
    end
    vectors++;
    if (n_stop - b_stop !== 1 || bus.busy_o !== 1'b0) begin
      miscompares++; $display("FAIL write_stop: got stops=%0d busy=%b want 1/0", n_stop - b_stop, bus.busy_o);
    end
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1;
    int unsigned b_oe = n_oe, b_rxv = n_rxv, b_stop = n_stop;
    m_start();
    m_write(8'hA2, a0);
    vectors++;
    if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL nomatch_busy: got %b want 0", bus.busy_o); end
    m_write(8'h12, a1);
    vectors++;
    if ({a0, a1} !== 2'b00 || n_oe != b_oe) begin
      miscompares++; $display("FAIL nomatch_sda: got acks=%b oe_cycles=%0d want 00/0", {a0, a1}, n_oe - b_oe);
    end
    m_stop();
    repeat (10) @(negedge clk);
    vectors++;
    if (n_rxv != b_rxv || n_stop - b_stop !== 1) begin
      miscompares++; $display("FAIL nomatch_rx_stop: got rxv=%0d stops=%0d want 0/1", n_rxv - b_rxv, n_stop - b_stop);
    end
  endtask

  task automatic test_read();
    logic a0;
    logic [7:0] r0, r1;
    int unsigned b_tq = n_txreq, b_mn = n_mnack;
    bus.tx_data_i = 8'hC3;
    m_start();
    m_write(8'hA1, a0);
    m_read(1'b1, 8'h5A, r0);
    m_read(1'b0, 8'h00, r1);
    m_stop();
    repeat (10) @(negedge clk);
    vectors++;
    if ({a0, r0, r1} !== {1'b1, 8'hC3, 8'h5A}) begin
      miscompares++; $display("FAIL read_bits: got ack=%b %b %b want 1 11000011 01011010", a0, r0, r1);
    end
    vectors++;
    if (n_txreq - b_tq !== 2 || n_mnack - b_mn !== 1) begin
      miscompares++; $display("FAIL read_pulses: got txreq=%0d mnack=%0d want 2/1", n_txreq - b_tq, n_mnack - b_mn);
    end
    vectors++;
    if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL read_busy: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2;
    logic [7:0] r0;
    int unsigned b_st = n_start, b_rx = rx_got.size();
    m_start();
    m_write(8'hA0, a0);
    m_write(8'h01, a1);
    bus.tx_data_i = 8'h96;
    m_start();
    m_write(8'hA1, a2);
    m_read(1'b0, 8'h00, r0);
    m_stop();
    repeat (10) @(negedge clk);
    vectors++;
    if (n_start - b_st !== 2) begin miscompares++; $display("FAIL sr_starts: got %0d want 2", n_start - b_st); end
    vectors++;
    if (rx_got.size() != b_rx + 1 || rx_got[b_rx] !== 8'h01) begin
      miscompares++; $display("FAIL sr_rx: got %0d bytes, want one byte 01", rx_got.size() - b_rx);
    end
    vectors++;
    if ({a0, a1, a2, r0} !== {3'b111, 8'h96}) begin
      miscompares++; $display("FAIL sr_tx: got acks=%b data=%h want 111/96", {a0, a1, a2}, r0);
    end
  endtask

  task automatic test_full_sink();
    logic a0, a1, a2;
    int unsigned b_rxv = n_rxv;
    m_start();
    m_write(8'hA0, a0);
    bus.rx_full_i = 1'b1;
    m_write(8'h77, a1);
    bus.rx_full_i = 1'b0;
    m_write(8'h55, a2);
    m_stop();
    repeat (10) @(negedge clk);
    vectors++;
    if ({a0, a1, a2} !== 3'b100 || n_rxv != b_rxv) begin
      miscompares++; $display("FAIL full_nack: got acks=%b rxv=%0d want 100/0", {a0, a1, a2}, n_rxv - b_rxv);
    end
  endtask

  task automatic test_mid_reset();
    logic s;
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(i == 7 || i == 5, s);
    vectors++;
    if (bus.sda_oe_o !== 1'b1) begin miscompares++; $display("FAIL midrst_ack_drive: got %b want 1", bus.sda_oe_o); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.sda_oe_o, bus.rx_data_o, bus.rx_valid_o, bus.tx_req_o, bus.master_nack_o,
         bus.start_o, bus.stop_o, bus.busy_o} !== 14'd0) begin
      miscompares++; $display("FAIL midrst_async: got oe=%b busy=%b rx=%h want 0/0/00",
                              bus.sda_oe_o, bus.busy_o, bus.rx_data_o);
    end
    m_scl = 1'b1;
    repeat (3) @(negedge clk);
    m_sda = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_glitch();
    int unsigned b_st = n_start;
    @(negedge clk) m_sda = 1'b0;
    @(negedge clk) m_sda = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    if (n_start != b_st) begin miscompares++; $display("FAIL glitch_start: got %0d starts want 0", n_start - b_st); end
`else
    if (n_start - b_st !== 1) begin miscompares++; $display("FAIL glitch_start: got %0d starts want 1", n_start - b_st); end
`endif
  endtask

  // Reference: a byte is ACKed only while the target is still engaged and its sink has room.
  task automatic test_random();
    logic [6:0] addr;
    logic rw, hit, alive, acked, got_ack;
    int unsigned nb, b_rx, b_tq, b_mn, b_st, b_sp;
    logic [7:0] data[3];
    logic full[3];
    logic [7:0] rd;
    logic [7:0] exp_rx[$];
    for (int t = 0; t < 10; t++) begin
      addr = ($urandom_range(1, 0) == 1) ? 7'h50 : 7'($urandom_range(127, 0));
      rw   = 1'($urandom_range(1, 0));
      nb   = $urandom_range(3, 1);
      for (int i = 0; i < 3; i++) begin
        data[i] = 8'($urandom_range(255, 0));
        full[i] = ($urandom_range(3, 0) == 0);
      end
      hit = (addr == 7'h50);
      exp_rx.delete();
      b_rx = rx_got.size(); b_tq = n_txreq; b_mn = n_mnack; b_st = n_start; b_sp = n_stop;
      bus.tx_data_i = data[0];
      m_start();
      m_write({addr, rw}, got_ack);
      vectors++;
      if (got_ack !== hit) begin miscompares++; $display("FAIL rnd_addr_ack t=%0d: got %b want %b", t, got_ack, hit); end
      alive = hit;
      for (int i = 0; i < int'(nb); i++) begin
        if (rw) begin
          m_read(i != int'(nb) - 1, (i < 2) ? data[i+1] : 8'h00, rd);
          vectors++;
          if (rd !== (hit ? data[i] : 8'hFF)) begin
            miscompares++; $display("FAIL rnd_read t=%0d b=%0d: got %h want %h", t, i, rd, hit ? data[i] : 8'hFF);
          end
        end else begin
          bus.rx_full_i = full[i];
          m_write(data[i], got_ack);
          bus.rx_full_i = 1'b0;
          acked = alive && !full[i];
          if (acked) exp_rx.push_back(data[i]);
          alive = acked;
          vectors++;
          if (got_ack !== acked) begin
            miscompares++; $display("FAIL rnd_write_ack t=%0d b=%0d: got %b want %b", t, i, got_ack, acked);
          end
        end
      end
      m_stop();
      repeat (10) @(negedge clk);
      vectors++;
      if (rx_got.size() - b_rx != exp_rx.size()) begin
        miscompares++; $display("FAIL rnd_rx_count t=%0d: got %0d want %0d", t, rx_got.size() - b_rx, exp_rx.size());
      end else begin
        for (int i = 0; i < exp_rx.size(); i++) begin
          vectors++;
          if (rx_got[b_rx + i] !== exp_rx[i]) begin
            miscompares++; $display("FAIL rnd_rx_data t=%0d b=%0d: got %h want %h", t, i, rx_got[b_rx + i], exp_rx[i]);
          end
        end
      end
      vectors++;
      if (n_txreq - b_tq != ((hit && rw) ? nb : 0) || n_mnack - b_mn != ((hit && rw) ? 1 : 0)) begin
        miscompares++; $display("FAIL rnd_tx_pulses t=%0d: got txreq=%0d mnack=%0d want %0d/%0d", t,
                                n_txreq - b_tq, n_mnack - b_mn, (hit && rw) ? nb : 0, (hit && rw) ? 1 : 0);
      end
      vectors++;
      if (n_start - b_st != 1 || n_stop - b_sp != 1 || bus.busy_o !== 1'b0) begin
        miscompares++; $display("FAIL rnd_framing t=%0d: got starts=%0d stops=%0d busy=%b want 1/1/0", t,
                                n_start - b_st, n_stop - b_sp, bus.busy_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read();
    test_repeated_start();
    test_full_sink();
    test_mid_reset();
    test_glitch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/i2c_slave_block.md
# i2c_slave_block

I2C target (slave) engine that answers the transactions issued by our I2C master. It runs from a single core clock and oversamples `scl_i` and `sda_i`. It detects START, repeated START and STOP, matches a fixed 7-bit address, and then does one of two things. For a master write it shifts in bytes and presents them on a valid-pulse interface. For a master read it requests bytes from the local logic and shifts them out. SDA is open-drain: the block only ever pulls it low.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit address this target answers to.
- `i2c_core_clock_i`  in  1  core clock; all logic is on its rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `scl_i`  in  1  SCL line level (asynchronous).
- `sda_i`  in  1  SDA line level (asynchronous).
- `sda_oe_o`  out  1  1 = pull SDA low; 0 = release.
- `rx_data_o`  out  8  last byte received from the master.
- `rx_valid_o`  out  1  1-cycle pulse; `rx_data_o` is updated in the same cycle.
- `rx_full_i`  in  1  local sink cannot take a byte; the byte is NACKed.
- `tx_data_i`  in  8  next byte to send; sampled on the edge where `tx_req_o` = 1.
- `tx_req_o`  out  1  1-cycle pulse; loads `tx_data_i` into the shifter.
- `master_nack_o`  out  1  1-cycle pulse; the master NACKed a read byte.
- `start_o` / `stop_o`  out  1  1-cycle pulses on a detected START (including repeated START) / STOP.
- `busy_o`  out  1  high from an address match until STOP, NACK-exit or START.

## Operation
- **Input conditioning**
  - Each line passes through a 2-flop synchronizer, then a registered previous-sample copy.
  - An edge is detected when the current and previous samples differ.
- **Bus conditions**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are detected in every state and override it.
  - START: go to ADDR, clear the bit counter, release SDA, pulse `start_o`.
  - STOP: go to IDLE, release SDA, pulse `stop_o`, clear `busy_o`.
- **Bit timing**
  - SDA is sampled on each detected SCL rise.
  - `sda_oe_o` changes only in the cycle after a detected SCL fall.
  - A 3-bit counter counts bits MSB first; the ACK slot is the 9th clock.
- **States:** IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT.
  - IDLE: ignore the bus except START.
  - ADDR: shift in 8 bits. On the 8th rise compare bits [7:1] with `SLAVE_ADDR`.
    - Match: go to ADDR_ACK and set `busy_o`.
    - Mismatch: go to WAIT. `sda_oe_o` stays 0.
    - General call is not supported.
  - ADDR_ACK: drive `sda_oe_o` = 1 from the fall after the 8th bit until the 9th fall.
    - At the 9th fall, R/W = 0: go to RX_DATA with SDA released.
    - At the 9th fall, R/W = 1: pulse `tx_req_o`, load the shifter, drive the MSB (`sda_oe_o` = ~bit), go to TX_DATA.
  - RX_DATA: on the 8th rise, check `rx_full_i`.
    - `rx_full_i` = 0: update `rx_data_o`, pulse `rx_valid_o`, go to RX_ACK with ACK.
    - `rx_full_i` = 1: no pulse, go to RX_ACK with NACK.
  - RX_ACK: drive ACK (`sda_oe_o` = 1) or release SDA for the 9th clock.
    - At the 9th fall after ACK: go to RX_DATA.
    - At the 9th fall after NACK: go to WAIT.
  - TX_DATA: shift out the next bit on each fall. At the 8th fall release SDA and go to TX_ACK.
  - TX_ACK: sample SDA on the 9th rise.
    - Low (ACK): at the next fall pulse `tx_req_o`, drive the MSB, go to TX_DATA.
    - High (NACK): pulse `master_nack_o`, clear `busy_o`, go to WAIT.
  - WAIT: SDA released; exit only on START or STOP.
- **Reset** (asynchronous, any time, including while driving SDA low):
  - `sda_oe_o` = 0, `rx_data_o` = 8'h00.
  - `rx_valid_o`, `tx_req_o`, `master_nack_o`, `start_o`, `stop_o`, `busy_o` = 0.
  - State = IDLE, counter = 0.

## Timing
- Line-to-internal latency: 3 cycles (synchronizer plus edge register).
- The ACK/data drive appears 1 cycle after the internal SCL-fall detect, i.e. 4 cycles after the line edge.
- The master must hold SCL high and low for at least 6 core cycles each.
- No clock stretching; `tx_data_i` must be valid at `tx_req_o`.
- A START and an SCL edge detected in the same cycle: START wins.
- A STOP detected in the ACK slot: STOP wins and SDA is released.

## Configuration
- `I2C_SLAVE_GLITCH_FILTER_EN` defined:
  - Each synchronized line passes through a 3-sample majority filter.
  - Latency rises to 5 cycles; the minimum SCL high/low rises to 8 cycles.
  - Single-cycle glitches are rejected.
- Not defined: no filter; timing as stated above.

## Test plan
- Write: addr 0x50/W, data 0xA5, 0x3C, STOP.
  - ACK in all 3 slots.
  - `rx_valid_o` pulses twice with 0xA5 then 0x3C.
  - `stop_o` pulses once; `busy_o` ends at 0.
- Address 0x51/W: `sda_oe_o` never 1, no `rx_valid_o`, `busy_o` stays 0, block in WAIT until STOP.
- Read: addr 0x50/R, `tx_data_i` 0xC3 then 0x5A; master ACKs the first byte and NACKs the second.
  - SDA bits are 11000011 then 01011010.
  - `tx_req_o` pulses twice; `master_nack_o` pulses once.
- Repeated START: write 0x50 with data 0x01, then Sr, then 0x50/R.
  - `start_o` pulses twice; 0x01 is received; the direction switches to TX.
- Full sink: `rx_full_i` = 1 during byte 0x77.
  - SDA is released in the 9th clock (NACK); no `rx_valid_o`; block enters WAIT.
- Mid-transfer reset: assert `reset_i` during ADDR_ACK.
  - `sda_oe_o` goes to 0 without a clock edge; all outputs reset.
  - With the macro defined, a 1-cycle SDA low pulse while SCL is high produces no `start_o`.
